// File: rtl/counter_compare_unit.sv
// PWM / compare / wrap tracker driven by an external up/down counter; all outputs but cmp_ready are registered (1 cycle).
// Compare writes land in a one-deep shadow slot (cmp_ready = slot empty) and take effect only at counter wrap.
module counter_compare_unit #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_up,
  input  logic [WIDTH-1:0] cmp_data,
  input  logic             cmp_valid,
  output logic             cmp_ready,
  output logic             pwm_out,
  output logic             match_pulse,
  output logic             wrap_pulse,
  output logic [7:0]       wrap_count
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  logic [WIDTH-1:0] prev_count;
  logic             prev_valid;
  logic [WIDTH-1:0] active_cmp;
  logic [WIDTH-1:0] shadow_cmp;
  logic             shadow_full;
  logic             wrap;
  logic             transfer;

  // prev_valid masks the bogus edge from the counter's reset value.
  always_comb begin
    wrap = 1'b0;
    if (prev_valid) begin
      if (count_up) wrap = (prev_count == ALL_ONES) && (count_in == ZERO);
      else          wrap = (prev_count == ZERO) && (count_in == ALL_ONES);
    end
  end

  assign cmp_ready = ~shadow_full;
  assign transfer  = cmp_valid & ~shadow_full;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev_count  <= '0;
      prev_valid  <= 1'b0;
      active_cmp  <= '0;
      shadow_cmp  <= '0;
      shadow_full <= 1'b0;
      pwm_out     <= 1'b0;
      match_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
      wrap_count  <= 8'd0;
    end else begin
      prev_count <= count_in;
      prev_valid <= 1'b1;

      // Transfer needs an empty slot and promotion a full one, so they never collide.
      if (transfer) begin
        shadow_cmp  <= cmp_data;
        shadow_full <= 1'b1;
      end else if (wrap && shadow_full) begin
        active_cmp  <= shadow_cmp;
        shadow_full <= 1'b0;
      end

      match_pulse <= (count_in == active_cmp);
      pwm_out     <= (count_in < active_cmp);
      wrap_pulse  <= wrap;
      if (wrap && (wrap_count != 8'hFF)) wrap_count <= wrap_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_counter_compare_unit.sv
// Directed bench for counter_compare_unit (WIDTH=3): idle, shadowed update, back-pressure, saturation, reset, down count.
module tb_counter_compare_unit;

  logic       clock;
  logic       resetn;
  logic [2:0] count_in;
  logic       count_up;
  logic [2:0] cmp_data;
  logic       cmp_valid;
  logic       cmp_ready;
  logic       pwm_out;
  logic       match_pulse;
  logic       wrap_pulse;
  logic [7:0] wrap_count;

  int vectors;
  int miscompares;

  counter_compare_unit #(.WIDTH(3)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .count_in    (count_in),
    .count_up    (count_up),
    .cmp_data    (cmp_data),
    .cmp_valid   (cmp_valid),
    .cmp_ready   (cmp_ready),
    .pwm_out     (pwm_out),
    .match_pulse (match_pulse),
    .wrap_pulse  (wrap_pulse),
    .wrap_count  (wrap_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one count, clock it in, check the registered outputs.
  task automatic apply(input logic [2:0] c, input logic ep, input logic em, input logic ew);
    count_in = c;
    tick();
    check("pwm_out", 32'(pwm_out), 32'(ep));
    check("match_pulse", 32'(match_pulse), 32'(em));
    check("wrap_pulse", 32'(wrap_pulse), 32'(ew));
  endtask

  initial begin
    logic [2:0] c;
    int exp_wc;
    vectors     = 0;
    miscompares = 0;
    resetn    = 1'b0;
    count_up  = 1'b1;
    count_in  = 3'd0;
    cmp_data  = 3'd0;
    cmp_valid = 1'b0;

    // Reset state
    #1;
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_match", 32'(match_pulse), 32'd0);
    check("rst_wrap", 32'(wrap_pulse), 32'd0);
    check("rst_wrap_count", 32'(wrap_count), 32'd0);
    check("rst_cmp_ready", 32'(cmp_ready), 32'd1);
    tick();
    tick();
    check("rst_hold_match", 32'(match_pulse), 32'd0);
    resetn = 1'b1;

    // Idle: compare 0, free-running up count
    for (int i = 0; i <= 16; i++) begin
      c = 3'(i % 8);
      apply(c, 1'b0, c == 3'd0, (i > 0) && (c == 3'd0));
    end
    check("idle_wrap_count", 32'(wrap_count), 32'd2);

    // Shadowed update: write 3 at count 5
    for (int i = 1; i <= 4; i++) apply(3'(i), 1'b0, 1'b0, 1'b0);
    cmp_valid = 1'b1;
    cmp_data  = 3'd3;
    apply(3'd5, 1'b0, 1'b0, 1'b0);
    cmp_valid = 1'b0;
    check("shadow_ready_low", 32'(cmp_ready), 32'd0);
    apply(3'd6, 1'b0, 1'b0, 1'b0);
    apply(3'd7, 1'b0, 1'b0, 1'b0);
    check("shadow_ready_still_low", 32'(cmp_ready), 32'd0);
    apply(3'd0, 1'b0, 1'b1, 1'b1);
    check("shadow_ready_back", 32'(cmp_ready), 32'd1);
    check("shadow_wrap_count", 32'(wrap_count), 32'd3);
    for (int i = 1; i <= 7; i++) apply(3'(i), i < 3, i == 3, 1'b0);
    apply(3'd0, 1'b1, 1'b0, 1'b1);

    // Back-pressure: 2 accepted, 6 held until ready rises
    cmp_valid = 1'b1;
    cmp_data  = 3'd2;
    apply(3'd1, 1'b1, 1'b0, 1'b0);
    check("bp_ready_low", 32'(cmp_ready), 32'd0);
    cmp_data = 3'd6;
    for (int i = 2; i <= 7; i++) begin
      apply(3'(i), i < 3, i == 3, 1'b0);
      check("bp_held_ready", 32'(cmp_ready), 32'd0);
    end
    apply(3'd0, 1'b1, 1'b0, 1'b1);
    check("bp_ready_after_wrap1", 32'(cmp_ready), 32'd1);
    apply(3'd1, 1'b1, 1'b0, 1'b0);
    cmp_valid = 1'b0;
    check("bp_second_accepted", 32'(cmp_ready), 32'd0);
    for (int i = 2; i <= 7; i++) apply(3'(i), i < 2, i == 2, 1'b0);
    apply(3'd0, 1'b1, 1'b0, 1'b1);
    check("bp_ready_after_wrap2", 32'(cmp_ready), 32'd1);
    for (int i = 1; i <= 7; i++) apply(3'(i), i < 6, i == 6, 1'b0);
    apply(3'd0, 1'b1, 1'b0, 1'b1);
    check("bp_wrap_count", 32'(wrap_count), 32'd7);

    // Saturation: 300 more wraps
    for (int w = 1; w <= 300; w++) begin
      for (int i = 1; i <= 7; i++) begin
        count_in = 3'(i);
        tick();
      end
      apply(3'd0, 1'b1, 1'b0, 1'b1);
      exp_wc = (7 + w > 255) ? 255 : 7 + w;
      check("sat_wrap_count", 32'(wrap_count), 32'(exp_wc));
    end

    // Mid-operation reset with active 5 and a pending shadow 7
    cmp_valid = 1'b1;
    cmp_data  = 3'd5;
    apply(3'd1, 1'b1, 1'b0, 1'b0);
    cmp_valid = 1'b0;
    for (int i = 2; i <= 7; i++) apply(3'(i), i < 6, i == 6, 1'b0);
    apply(3'd0, 1'b1, 1'b0, 1'b1);
    cmp_valid = 1'b1;
    cmp_data  = 3'd7;
    apply(3'd1, 1'b1, 1'b0, 1'b0);
    cmp_valid = 1'b0;
    check("mr_shadow_full", 32'(cmp_ready), 32'd0);
    apply(3'd2, 1'b1, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("mr_pwm", 32'(pwm_out), 32'd0);
    check("mr_match", 32'(match_pulse), 32'd0);
    check("mr_wrap", 32'(wrap_pulse), 32'd0);
    check("mr_wrap_count", 32'(wrap_count), 32'd0);
    check("mr_cmp_ready", 32'(cmp_ready), 32'd1);
    count_in = 3'd0;
    tick();
    resetn = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      c = 3'(i % 8);
      apply(c, 1'b0, c == 3'd0, (i > 0) && (c == 3'd0));
    end
    check("mr_after_wrap_count", 32'(wrap_count), 32'd2);

    // Down counter: starts at 7 after reset, compare 4 written at count 5
    resetn   = 1'b0;
    count_up = 1'b0;
    count_in = 3'd7;
    tick();
    resetn = 1'b1;
    for (int i = 0; i <= 24; i++) begin
      c = 3'(7 - (i % 8));
      if (i == 2) begin
        cmp_valid = 1'b1;
        cmp_data  = 3'd4;
      end
      if (i <= 8) apply(c, 1'b0, c == 3'd0, (i > 0) && (c == 3'd7));
      else        apply(c, c < 3'd4, c == 3'd4, c == 3'd7);
      if (i == 2) begin
        cmp_valid = 1'b0;
        check("dn_ready_low", 32'(cmp_ready), 32'd0);
      end
      if (i == 8) check("dn_ready_back", 32'(cmp_ready), 32'd1);
    end
    check("dn_wrap_count", 32'(wrap_count), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_compare_unit.md
# counter_compare_unit

Downstream consumer of the N-bit up/down counter. Samples the counter's `Q` every clock and produces a registered PWM output, a compare-match pulse, a wrap pulse and a saturating wrap counter. Compare values are written through a valid/ready handshake into a shadow register. The shadow value is promoted to the active compare only at counter wrap, so PWM periods are never torn.

## Interface
- `WIDTH`, default 3: counter width; must match the upstream counter.
- `clock`  in  1: rising-edge clock, same clock as the counter.
- `resetn`  in  1: reset, asynchronous, active-low.
- `count_in`  in  WIDTH: counter value `Q`.
- `count_up`  in  1: direction. 1 = counter increments; 0 = counter decrements. Static; a change is legal only while `resetn` is low.
- `cmp_data`  in  WIDTH: new compare value.
- `cmp_valid`  in  1: `cmp_data` is valid.
- `cmp_ready`  out  1: shadow slot is empty.
- `pwm_out`  out  1: PWM level.
- `match_pulse`  out  1: one-cycle pulse when the count equals the active compare.
- `wrap_pulse`  out  1: one-cycle pulse on counter wrap.
- `wrap_count`  out  8: number of wraps since reset; saturates at 255.

## Operation
- **Registers**
  - `prev_count`: WIDTH bits.
  - `prev_valid`: 1 bit.
  - `active_cmp`: WIDTH bits.
  - `shadow_cmp`: WIDTH bits.
  - `shadow_full`: 1 bit.
  - Output flops: `pwm_out`, `match_pulse`, `wrap_pulse`, `wrap_count`.
- **Reset values**
  - All registers clear to 0.
  - `cmp_ready` = 1, because `shadow_full` = 0.
  - `pwm_out`, `match_pulse`, `wrap_pulse` = 0; `wrap_count` = 0.
- **`prev_valid`** sets on the first edge after reset release. Wrap detection is suppressed while it is 0. This prevents a false wrap from the counter's reset value (0 when counting up, all-ones when counting down).
- **Wrap detect** (combinational, internal `wrap`), requires `prev_valid`:
  - Up: `prev_count` = all-ones and `count_in` = 0.
  - Down: `prev_count` = 0 and `count_in` = all-ones.
  - Any other discontinuity is not a wrap.
- **Handshake**
  - `cmp_ready` = ~`shadow_full` (combinational from the flop only; no dependence on `cmp_valid`).
  - Transfer occurs on an edge where `cmp_valid` && `cmp_ready`: `shadow_cmp` <= `cmp_data`, `shadow_full` <= 1.
  - `cmp_data` is ignored when `cmp_ready` is 0; the producer holds its data.
- **Promotion**
  - On an edge with `wrap` && `shadow_full`: `active_cmp` <= `shadow_cmp`, `shadow_full` <= 0.
  - If a transfer and a wrap occur on the same edge, `shadow_full` was 0, so there is nothing to promote. The new value waits for the next wrap.
- **Compare**
  - Uses the `active_cmp` value from before any same-edge promotion.
  - `match_pulse` <= (`count_in` == `active_cmp`).
  - `pwm_out` <= (`count_in` < `active_cmp`), unsigned, for both directions.
  - Consequences: `active_cmp` = 0 gives constant-low PWM. `active_cmp` = all-ones gives high on every count except all-ones.
- **Wrap outputs**
  - `wrap_pulse` <= `wrap`.
  - `wrap_count` <= `wrap_count` + 1 on `wrap`, unless it is already 255.

## Timing
- All outputs except `cmp_ready` are registered. Latency is 1 cycle: a `count_in` sampled at edge N is reflected in the outputs after edge N.
- `wrap_pulse` is high exactly one cycle per wrap. At least one cycle passes between pulses. With WIDTH=1, pulses can occur every other cycle.
- A compare written via the handshake first affects `pwm_out`/`match_pulse` on the cycle after the edge that samples the next wrap.
- `cmp_ready` falls the cycle after a transfer. It rises the cycle after the promoting wrap edge.
- Asserting `resetn` low at any point:
  - immediately clears all state and outputs;
  - drops any pending shadow value;
  - returns `active_cmp` to 0.
- After release, the first edge only sets `prev_valid`; no wrap is possible on that edge.

## Test plan
- **Reset/idle:** WIDTH=3, `count_up`=1, counter free-running 0..7, no writes. Expect `pwm_out`=0 always. `match_pulse` is high 1 cycle after each sample of 0. `wrap_pulse` is high 1 cycle after each 7->0 sample. `wrap_count` increments by 1 per wrap.
- **Shadowed update, up:** write `cmp_data`=3 mid-period at count 5. Expect `cmp_ready` low from the next cycle, and `pwm_out` unchanged until the wrap. After the 7->0 wrap, `pwm_out`=1 for counts 0,1,2 and 0 for 3..7, `match_pulse` at count 3, and `cmp_ready` high again.
- **Down counter:** `count_up`=0, counter starts at 7 after reset. Expect no `wrap_pulse` on the first edge. After the first 0->7 transition, expect a `wrap_pulse`. With compare 4 promoted, `pwm_out`=1 for counts 3,2,1,0.
- **Back-pressure/same-edge:** write 2 (accepted). Hold `cmp_valid` with 6 while `cmp_ready`=0; expect no transfer. Expect wrap #1 to promote 2. The held 6 transfers the cycle `cmp_ready` rises, and is promoted at wrap #2, not earlier.
- **Saturation:** run 300 wraps. Expect `wrap_count` to stop at 255 while `wrap_pulse` keeps pulsing.
- **Mid-operation reset:** assert `resetn` low with `shadow_full`=1 and `active_cmp`=5. Expect all outputs 0 and `cmp_ready`=1 immediately. After release, the old shadow value is never promoted.
